// File: rtl/mul_share_arbiter.sv
// Round-robin share of one online signed-digit multiplier between two
// requesters, with a drain watchdog that recovers a stalled multiplier.
module mul_share_arbiter #(
   parameter int DIGITS  = 8,
   parameter int TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_vd,
   output logic       req0_rd,
   input  logic [1:0] req0_x,
   input  logic [1:0] req0_y,
   output logic       rsp0_vd,
   input  logic       rsp0_rd,
   output logic [1:0] rsp0_p,
   input  logic       req1_vd,
   output logic       req1_rd,
   input  logic [1:0] req1_x,
   input  logic [1:0] req1_y,
   output logic       rsp1_vd,
   input  logic       rsp1_rd,
   output logic [1:0] rsp1_p,
   output logic [1:0] mul_x,
   output logic [1:0] mul_y,
   output logic       mul_In_vd,
   input  logic       mul_In_rd,
   input  logic [1:0] mul_p,
   input  logic       mul_Out_vd,
   output logic       mul_Out_rd,
   output logic       owner,
   output logic       busy,
   output logic       err
);
   localparam int CW = $clog2(DIGITS + 1);
   localparam int WW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST   = CW'(DIGITS);
   localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t        state;
   logic          last_owner;
   logic [CW-1:0] iss_cnt;
   logic [CW-1:0] ret_cnt;
   logic [WW-1:0] wd_cnt;
   logic          in_act;
   logic          out_act;
   logic          iss_hs;
   logic          ret_hs;
   logic          grant;
   logic [CW-1:0] iss_nxt;
   logic [CW-1:0] ret_nxt;

   assign in_act  = (state == ISSUE);
   assign out_act = (state != IDLE);
   assign iss_hs  = mul_In_vd & mul_In_rd;
   assign ret_hs  = mul_Out_vd & mul_Out_rd;
   assign iss_nxt = iss_cnt + CW'(iss_hs);
   assign ret_nxt = ret_cnt + CW'(ret_hs);
   // on a tie the requester that was not served last wins
   assign grant   = (req0_vd & req1_vd) ? ~last_owner : req1_vd;

   always_comb begin
      mul_x      = '0;
      mul_y      = '0;
      mul_In_vd  = 1'b0;
      req0_rd    = 1'b0;
      req1_rd    = 1'b0;
      rsp0_vd    = 1'b0;
      rsp1_vd    = 1'b0;
      rsp0_p     = '0;
      rsp1_p     = '0;
      mul_Out_rd = 1'b0;
      if (in_act) begin
         mul_x     = owner ? req1_x : req0_x;
         mul_y     = owner ? req1_y : req0_y;
         mul_In_vd = owner ? req1_vd : req0_vd;
         req0_rd   = ~owner & mul_In_rd;
         req1_rd   = owner & mul_In_rd;
      end
      if (out_act) begin
         rsp0_vd    = ~owner & mul_Out_vd;
         rsp1_vd    = owner & mul_Out_vd;
         rsp0_p     = owner ? 2'b00 : mul_p;
         rsp1_p     = owner ? mul_p : 2'b00;
         mul_Out_rd = owner ? rsp1_rd : rsp0_rd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         owner      <= 1'b0;
         last_owner <= 1'b1;
         iss_cnt    <= '0;
         ret_cnt    <= '0;
         wd_cnt     <= '0;
         err        <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req0_vd | req1_vd) begin
                  owner   <= grant;
                  iss_cnt <= '0;
                  ret_cnt <= '0;
                  wd_cnt  <= '0;
                  state   <= ISSUE;
                  busy    <= 1'b1;
               end
            end
            ISSUE: begin
               iss_cnt <= iss_nxt;
               ret_cnt <= ret_nxt;
               if (ret_nxt == LAST) begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  last_owner <= owner;
               end else if (iss_nxt == LAST) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               ret_cnt <= ret_nxt;
               if (ret_hs) begin
                  wd_cnt <= '0;
                  if (ret_nxt == LAST) begin
                     state      <= IDLE;
                     busy       <= 1'b0;
                     last_owner <= owner;
                  end
               end else if (wd_cnt == WD_MAX) begin
                  err        <= 1'b1;
                  state      <= IDLE;
                  busy       <= 1'b0;
                  last_owner <= owner;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: two requester drivers, an online
// multiplier model with adjustable delay/stall, and a result scoreboard.
module tb_mul_share_arbiter;
   localparam int DIG = 8;
   localparam int TMO = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [1:0]      req_vd, req_rd, rsp_vd, rsp_rd;
   logic [1:0][1:0] req_x, req_y, rsp_p;
   logic [1:0]      mul_x, mul_y, mul_p;
   logic            mul_In_vd, mul_In_rd, mul_Out_vd, mul_Out_rd;
   logic            owner, busy, err;

   int n_chk = 0;
   int n_fail = 0;

   mul_share_arbiter #(.DIGITS(DIG), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .req0_vd(req_vd[0]), .req0_rd(req_rd[0]),
      .req0_x(req_x[0]), .req0_y(req_y[0]),
      .rsp0_vd(rsp_vd[0]), .rsp0_rd(rsp_rd[0]), .rsp0_p(rsp_p[0]),
      .req1_vd(req_vd[1]), .req1_rd(req_rd[1]),
      .req1_x(req_x[1]), .req1_y(req_y[1]),
      .rsp1_vd(rsp_vd[1]), .rsp1_rd(rsp_rd[1]), .rsp1_p(rsp_p[1]),
      .mul_x(mul_x), .mul_y(mul_y),
      .mul_In_vd(mul_In_vd), .mul_In_rd(mul_In_rd),
      .mul_p(mul_p), .mul_Out_vd(mul_Out_vd), .mul_Out_rd(mul_Out_rd),
      .owner(owner), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // multiplier model: digit j out after j+1+mdly digits in, stalls at mstop
   int         mdly = 3;
   int         mstop = DIG;
   int         n_in = 0;
   int         n_out = 0;
   logic [1:0] mem [DIG];

   assign mul_In_rd = 1'b1;

   always_comb begin
      mul_Out_vd = 1'b0;
      mul_p = mul_x ^ mul_y;
      if (busy && n_out < DIG && n_out < mstop) begin
         if (mdly == 0)
            mul_Out_vd = (n_out < n_in) || (mul_In_vd && mul_In_rd);
         else
            mul_Out_vd = (n_out + mdly < n_in) || (n_in == DIG && n_out < n_in);
      end
      if (n_out < n_in && n_out < DIG) mul_p = mem[n_out];
   end

   always_ff @(posedge clk) begin
      if (!busy) begin
         n_in <= 0;
         n_out <= 0;
      end else begin
         if (mul_In_vd && mul_In_rd) begin
            if (n_in < DIG) mem[n_in] <= mul_x ^ mul_y;
            n_in <= n_in + 1;
         end
         if (mul_Out_vd && mul_Out_rd) n_out <= n_out + 1;
      end
   end

   logic [1:0] q [2][$];
   logic [1:0] own_q [$];
   int   ops [2];
   int   idx [2];
   int   iss_tot [2];
   int   ret_tot [2];
   int   cyc = 0, last_ret_cyc = 0, fall_cyc = 0, busy_cyc = 0, drain_cnt = 0;
   logic prev_busy = 1'b0;
   logic s_busy, s_owner, s_err;
   logic [9:0] s_out;
   logic quiet1 = 1'b0, bp_en = 1'b0, bp_chk = 1'b0, dchk = 1'b0;
   logic [3:0] bp_pat = 4'b1001;
   int   bp_ph = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      logic [1:0] ihs, ohs;
      @(negedge clk);
      cyc++;
      ihs = req_vd & req_rd;
      ohs = rsp_vd & rsp_rd;
      s_busy = busy;
      s_owner = owner;
      s_err = err;
      s_out = {req_rd, rsp_vd, mul_In_vd, mul_Out_rd, mul_x, mul_y};
      for (int r = 0; r < 2; r++) begin
         if (ihs[r]) begin
            q[r].push_back(req_x[r] ^ req_y[r]);
            iss_tot[r]++;
         end
      end
      for (int r = 0; r < 2; r++) begin
         if (ohs[r]) begin
            ret_tot[r]++;
            last_ret_cyc = cyc;
            if (q[r].size() == 0) chk($sformatf("rsp%0d_extra", r), 1, 0);
            else chk($sformatf("rsp%0d_p", r), rsp_p[r], q[r].pop_front());
         end
      end
      if (busy && !prev_busy) own_q.push_back(owner);
      if (!busy && prev_busy) fall_cyc = cyc;
      if (busy) busy_cyc++;
      prev_busy = busy;
      if (!busy) chk("idle_quiet", s_out, '0);
      if (quiet1) chk("req1_quiet", {req_rd[1], rsp_vd[1]}, 0);
      if (bp_chk && busy) chk("out_rd_mirror", mul_Out_rd, rsp_rd[0]);
      if (dchk && busy && req_vd[0] && !mul_In_vd) drain_cnt++;
      @(posedge clk);
      #1;
      for (int r = 0; r < 2; r++) begin
         if (ihs[r]) begin
            idx[r]++;
            if (idx[r] == DIG) begin
               idx[r] = 0;
               ops[r]--;
            end
            req_x[r] = 2'($urandom_range(0, 3));
            req_y[r] = 2'($urandom_range(0, 3));
         end
         req_vd[r] = (ops[r] > 0);
      end
      if (bp_en) begin
         bp_ph = (bp_ph + 1) % 4;
         rsp_rd[0] = bp_pat[bp_ph];
      end
   endtask

   task automatic clr();
      for (int r = 0; r < 2; r++) begin
         q[r].delete();
         iss_tot[r] = 0;
         ret_tot[r] = 0;
         idx[r] = 0;
      end
      own_q.delete();
      busy_cyc = 0;
      drain_cnt = 0;
   endtask

   task automatic go(input int o0, input int o1);
      ops[0] = o0;
      ops[1] = o1;
      req_vd[0] = (o0 > 0);
      req_vd[1] = (o1 > 0);
   endtask

   task automatic run(input string tag, input int budget);
      int n = 0;
      do begin
         step();
         n++;
      end while ((ops[0] > 0 || ops[1] > 0 || s_busy) && n < budget);
      if (n >= budget) chk({tag, "_timeout"}, 1, 0);
   endtask

   initial begin
      req_vd = '0;
      rsp_rd = 2'b11;
      req_x = '0;
      req_y = '0;
      ops[0] = 0;
      ops[1] = 0;
      clr();
      repeat (3) step();
      chk("rst_busy", s_busy, 0);
      chk("rst_owner", s_owner, 0);
      chk("rst_err", s_err, 0);
      rst = 1'b0;

      // single operation, requester 0
      quiet1 = 1'b1;
      go(1, 0);
      step();
      chk("grant_lat_t", s_busy, 0);
      step();
      chk("grant_lat_t1", s_busy, 1);
      chk("first_rd", s_out[8], 1);
      chk("t1_owner", s_owner, 0);
      run("single", 100);
      chk("single_iss", iss_tot[0], DIG);
      chk("single_ret", ret_tot[0], DIG);
      chk("single_left", q[0].size(), 0);
      chk("single_release", fall_cyc, last_ret_cyc + 1);
      quiet1 = 1'b0;

      // contention from reset release: owners alternate 0,1,0,1
      rst = 1'b1;
      step();
      clr();
      go(2, 2);
      rst = 1'b0;
      run("contend", 300);
      chk("rr_cnt", own_q.size(), 4);
      for (int i = 0; i < 4 && i < own_q.size(); i++)
         chk($sformatf("rr_owner%0d", i), own_q[i], i % 2);
      chk("rr_ret0", ret_tot[0], 2 * DIG);
      chk("rr_ret1", ret_tot[1], 2 * DIG);

      // backpressure 1-0-0-1 on rsp0_rd
      clr();
      quiet1 = 1'b1;
      bp_en = 1'b1;
      bp_ph = 0;
      rsp_rd[0] = bp_pat[0];
      bp_chk = 1'b1;
      go(1, 0);
      run("bp", 200);
      chk("bp_ret", ret_tot[0], DIG);
      chk("bp_left", q[0].size(), 0);
      bp_en = 1'b0;
      bp_chk = 1'b0;
      rsp_rd = 2'b11;

      // zero-delay multiplier: last issue and last return coincide
      clr();
      mdly = 0;
      dchk = 1'b1;
      go(2, 0);
      run("d0", 200);
      chk("d0_drain", drain_cnt, 0);
      chk("d0_busy_cycles", busy_cyc, 2 * DIG);
      chk("d0_ret", ret_tot[0], 2 * DIG);
      dchk = 1'b0;
      mdly = 3;

      // watchdog: multiplier stalls after five results
      clr();
      mstop = 5;
      go(1, 0);
      begin
         int n = 0;
         while (ret_tot[0] < 5 && n < 100) begin
            step();
            n++;
         end
         chk("wd_five", ret_tot[0], 5);
         n = 0;
         do begin
            step();
            n++;
         end while (s_busy && n < 100);
         chk("wd_busy_cycles", n - 1, TMO);
         chk("wd_err", s_err, 1);
      end
      mstop = DIG;
      quiet1 = 1'b0;
      clr();
      go(1, 1);
      run("post_wd", 300);
      chk("post_wd_cnt", own_q.size(), 2);
      if (own_q.size() > 0) chk("post_wd_owner", own_q[0], 1);
      chk("err_sticky", s_err, 1);

      // reset mid-ISSUE after three issues
      clr();
      go(1, 0);
      begin
         int n = 0;
         while (iss_tot[0] < 3 && n < 50) begin
            step();
            n++;
         end
         chk("mid_three", iss_tot[0], 3);
      end
      rst = 1'b1;
      go(0, 0);
      step();
      rst = 1'b0;
      step();
      chk("mid_rst_busy", s_busy, 0);
      chk("mid_rst_owner", s_owner, 0);
      chk("mid_rst_err", s_err, 0);
      chk("mid_rst_out", s_out, 0);
      clr();
      go(1, 1);
      run("post_rst", 300);
      chk("post_rst_cnt", own_q.size(), 2);
      if (own_q.size() > 0) chk("post_rst_owner", own_q[0], 0);
      chk("post_rst_ret0", ret_tot[0], DIG);
      chk("post_rst_ret1", ret_tot[1], DIG);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1);
   end

endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin arbiter that shares one online signed-digit multiplier datapath between two requesters (e.g. two Newton-iteration stages). It grants the multiplier to one requester for a complete operation of DIGITS digit pairs and routes that requester's digit stream into the multiplier's input handshake. It routes the multiplier's output digits back to the same requester and releases the grant only after all DIGITS result digits have been accepted. A watchdog recovers the arbiter if the multiplier stops producing digits.

## Interface
Parameters:
- DIGITS, 8, digit pairs issued and result digits returned per operation (≥1)
- TIMEOUT, 64, idle cycles tolerated in DRAIN before abort (≥2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req0_vd  in  1  requester 0 input digit valid
- req0_rd  out  1  requester 0 input digit accepted
- req0_x, req0_y  in  2 each  requester 0 operand digits (opaque signed-digit code)
- rsp0_vd  out  1  result digit valid to requester 0
- rsp0_rd  in  1  requester 0 ready for result digit
- rsp0_p  out  2  result digit to requester 0
- req1_*/rsp1_*  same as requester 0
- mul_x, mul_y  out  2 each  operand digits to multiplier
- mul_In_vd  out  1  operand valid to multiplier
- mul_In_rd  in  1  multiplier accepted operand
- mul_p  in  2  multiplier result digit
- mul_Out_vd  in  1  multiplier result valid
- mul_Out_rd  out  1  result accepted
- owner  out  1  current grant (valid when busy=1)
- busy  out  1  state != IDLE
- err  out  1  sticky watchdog abort flag

## Operation
- States: IDLE, ISSUE, DRAIN. Registers: state, owner, last_owner, iss_cnt, ret_cnt, wd_cnt, err. Counter width is $clog2(DIGITS+1).
- IDLE: if exactly one reqN_vd=1, grant that requester. If both, grant !last_owner. Set owner, clear iss_cnt/ret_cnt/wd_cnt, go ISSUE. No handshake completes in IDLE: all *_rd/*_vd outputs are 0 and mul_x/mul_y are 0.
- ISSUE, combinational pass-through selected by registered owner:
  - mul_x/mul_y = req_owner x/y
  - mul_In_vd = req_owner_vd
  - req_owner_rd = mul_In_rd
  - Non-owner req_rd=0.
- Issue handshake (mul_In_vd & mul_In_rd) increments iss_cnt. When iss_cnt reaches DIGITS, go DRAIN.
- ISSUE and DRAIN output path:
  - rsp_owner_vd = mul_Out_vd, rsp_owner_p = mul_p, mul_Out_rd = rsp_owner_rd
  - Non-owner rsp_vd=0, p=0.
  - Each return handshake increments ret_cnt.
- DRAIN: mul_In_vd=0, all req_rd=0.
- Leaving to IDLE: ret_cnt reaches DIGITS (from ISSUE or DRAIN), then last_owner<=owner.
- Simultaneous events:
  - Last issue and last return in the same cycle go directly to IDLE.
  - A return handshake with ret_cnt==DIGITS cannot occur, because the state has already left.
- Watchdog, active in DRAIN only:
  - wd_cnt increments each cycle without a return handshake and clears on a handshake.
  - When wd_cnt reaches TIMEOUT-1 with no handshake: set err, go IDLE, last_owner<=owner.
- err clears only on rst.
- Reset: state=IDLE, owner=0, last_owner=1 (requester 0 wins first tie), counters=0, err=0. All outputs are 0 the cycle after rst. rst asserted mid-operation abandons the operation without flushing the multiplier.

## Timing
- Grant latency: reqN_vd high in IDLE at cycle t gives ISSUE at t+1. The first req_rd can be high at t+1.
- Zero added latency on the data paths: pure mux of registered owner/state.
- Release: last return handshake at cycle t gives IDLE at t+1. The next operation enters ISSUE at t+2 at the earliest.
- Back-to-back contention alternates owners. A single active requester is re-granted every operation.
- busy, owner, err are registered.

## Test plan
- Single operation, requester 0 only, DIGITS=8, model multiplier with online delay 3:
  - 8 issue handshakes, then 8 rsp0 digits matching the model.
  - busy high from t+1 until the cycle after the 8th return.
  - req1_rd/rsp1_vd stay 0 throughout.
- Both req0_vd and req1_vd asserted at reset release:
  - req0 is served first, then req1.
  - A third request from both is granted to req0. Owner sequence is 0,1,0.
- Backpressure:
  - rsp0_rd toggled 1-0-0-1 causes mul_Out_rd to mirror it and ret_cnt to advance only on rd=1 cycles.
  - The operation still completes after exactly 8 returns.
- Last issue and last return in the same cycle (model delay 0, DIGITS=4):
  - Goes directly ISSUE→IDLE and never enters DRAIN.
- Watchdog, TIMEOUT=16: the model stops returning after 5 digits.
  - err=1 and busy=0 exactly 16 cycles after the 5th return.
  - The next request is granted to the other requester.
  - err stays 1 until rst.
- rst pulsed mid-ISSUE after 3 issues:
  - Next cycle: busy=0, owner=0, all rd/vd=0, err=0.
  - The subsequent request is granted normally.
